// File: rtl/maze_credit_pkg.sv
// Shared types and helpers for the MAZE credit-based link (transmitter and receiver sides).
package maze_credit_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) == 0, so callers size counters with clog2(max+1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage : maze_credit_pkg

// File: rtl/maze_credit_cnt.sv
// Saturating credit counter: starts full, counts down on sends and up on returns, flags overflow.
module maze_credit_cnt
  import maze_credit_pkg::*;
#(
  parameter int CREDIT_NUM = 4,
  parameter int CNT_W      = clog2(CREDIT_NUM + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_NUM);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_d;

  // A simultaneous return and send cancel; a return into a full counter is an overflow.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_MAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign err_o   = err_q;

endmodule : maze_credit_cnt

// File: rtl/maze_credit_tx.sv
// MAZE long-link credit transmitter: valid/ready in, registered valid-only link out, flush handshake.
module maze_credit_tx
  import maze_credit_pkg::*;
#(
  parameter int PYLD_W     = 1,
  parameter int CREDIT_NUM = 4,
  parameter int INIT_CYC   = 2,
  parameter int CNT_W      = clog2(CREDIT_NUM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [PYLD_W-1:0] payload_i,
  output logic              valid_o,
  output logic [PYLD_W-1:0] payload_o,
  input  logic              credit_i,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic [CNT_W-1:0]  credit_cnt_o,
  output logic              err_o
);

  localparam int               INIT_W      = (INIT_CYC > 2) ? clog2(INIT_CYC) : 1;
  localparam logic [INIT_W-1:0] INIT_LOAD  = INIT_W'((INIT_CYC > 0) ? (INIT_CYC - 1) : 0);
  localparam state_e           RESET_STATE = (INIT_CYC == 0) ? ST_ACTIVE : ST_INIT;

  state_e              state_q;
  state_e              state_d;
  logic [INIT_W-1:0]   init_cnt_q;
  logic [INIT_W-1:0]   init_cnt_d;
  logic                valid_q;
  logic                valid_d;
  logic [PYLD_W-1:0]   payload_q;
  logic [PYLD_W-1:0]   payload_d;

  logic                fire;
  logic                cnt_full;
  logic                cnt_empty;

  // Credits are counted in every state, so returns during INIT and DRAIN are never lost.
  maze_credit_cnt #(
    .CREDIT_NUM (CREDIT_NUM),
    .CNT_W      (CNT_W)
  ) u_credit_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (credit_i),
    .dec_i   (fire),
    .cnt_o   (credit_cnt_o),
    .full_o  (cnt_full),
    .empty_o (cnt_empty),
    .err_o   (err_o)
  );

  assign ready_o      = (state_q == ST_ACTIVE) && !cnt_empty;
  assign fire         = valid_i && ready_o;
  assign flush_done_o = (state_q == ST_DRAIN) && cnt_full;

  // A fire coincident with flush_i still goes out; DRAIN only blocks from the next cycle.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          init_cnt_d = init_cnt_q - INIT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!flush_i && cnt_full) begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_comb begin
    valid_d   = fire;
    payload_d = fire ? payload_i : payload_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      init_cnt_q <= INIT_LOAD;
      valid_q    <= 1'b0;
      payload_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      valid_q    <= valid_d;
      payload_q  <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule : maze_credit_tx

// File: tb/tb_maze_credit_tx.sv
// Directed bench for maze_credit_tx: init gating, credit exhaustion, back-to-back, flush, overflow, reset.
module tb_maze_credit_tx;

  localparam int PYLD_W     = 8;
  localparam int CREDIT_NUM = 4;
  localparam int INIT_CYC   = 2;
  localparam int CNT_W      = 3;

  logic              clk;
  logic              rst_n;
  logic              valid_i;
  logic              ready_o;
  logic [PYLD_W-1:0] payload_i;
  logic              valid_o;
  logic [PYLD_W-1:0] payload_o;
  logic              credit_i;
  logic              flush_i;
  logic              flush_done_o;
  logic [CNT_W-1:0]  credit_cnt_o;
  logic              err_o;

  int checkCount;
  int errorCount;

  maze_credit_tx #(
    .PYLD_W     (PYLD_W),
    .CREDIT_NUM (CREDIT_NUM),
    .INIT_CYC   (INIT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .payload_i    (payload_i),
    .valid_o      (valid_o),
    .payload_o    (payload_o),
    .credit_i     (credit_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .credit_cnt_o (credit_cnt_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (actual !== expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive inputs at the falling edge, clock once, and return at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [PYLD_W-1:0] p, input logic c, input logic f);
    valid_i   = v;
    payload_i = p;
    credit_i  = c;
    flush_i   = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkLink(input string tag, input logic v, input logic [PYLD_W-1:0] p,
                           input logic [CNT_W-1:0] c, input logic r);
    checkOutput({tag, ".valid"}, 32'(valid_o), 32'(v));
    checkOutput({tag, ".payload"}, 32'(payload_o), 32'(p));
    checkOutput({tag, ".cnt"}, 32'(credit_cnt_o), 32'(c));
    checkOutput({tag, ".ready"}, 32'(ready_o), 32'(r));
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    valid_i    = 1'b0;
    payload_i  = '0;
    credit_i   = 1'b0;
    flush_i    = 1'b0;
    repeat (3) @(negedge clk);

    checkLink("reset", 1'b0, 8'h00, 3'd4, 1'b0);
    checkOutput("reset.err", 32'(err_o), 32'd0);
    checkOutput("reset.done", 32'(flush_done_o), 32'd0);

    // Test 1: INIT holds ready low for two cycles with valid pending.
    rst_n     = 1'b1;
    valid_i   = 1'b1;
    payload_i = 8'h01;
    checkOutput("init.c0.ready", 32'(ready_o), 32'd0);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    checkOutput("init.c1.ready", 32'(ready_o), 32'd0);
    checkOutput("init.c1.valid", 32'(valid_o), 32'd0);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    checkLink("init.active", 1'b0, 8'h00, 3'd4, 1'b1);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    checkLink("t1.first", 1'b1, 8'h01, 3'd3, 1'b1);

    // Test 2: burst continues until credits run out.
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
    checkLink("t2.f2", 1'b1, 8'h02, 3'd2, 1'b1);
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
    checkLink("t2.f3", 1'b1, 8'h03, 3'd1, 1'b1);
    applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
    checkLink("t2.f4", 1'b1, 8'h04, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    checkLink("t2.stall1", 1'b0, 8'h04, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    checkLink("t2.stall2", 1'b0, 8'h04, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h05, 1'b1, 1'b0);
    checkLink("t2.credit", 1'b0, 8'h04, 3'd1, 1'b1);
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    checkLink("t2.f5", 1'b1, 8'h05, 3'd0, 1'b0);

    // Test 3: refill to one, then send and return every cycle.
    applyStimulus(1'b1, 8'h06, 1'b1, 1'b0);
    checkLink("t3.refill", 1'b0, 8'h05, 3'd1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'(8'h10 + k), 1'b1, 1'b0);
      checkLink($sformatf("t3.b2b%0d", k), 1'b1, 8'(8'h10 + k), 3'd1, 1'b1);
    end
    applyStimulus(1'b0, 8'hAA, 1'b0, 1'b0);
    checkLink("t3.idle", 1'b0, 8'h13, 3'd1, 1'b1);

    // Test 4: flush with two credits outstanding.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkLink("t4.pre", 1'b0, 8'h13, 3'd2, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkLink("t4.drain", 1'b0, 8'h13, 3'd2, 1'b0);
    checkOutput("t4.drain.done", 32'(flush_done_o), 32'd0);
    applyStimulus(1'b1, 8'h20, 1'b0, 1'b1);
    checkLink("t4.blocked", 1'b0, 8'h13, 3'd2, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("t4.c3.done", 32'(flush_done_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkLink("t4.home", 1'b0, 8'h13, 3'd4, 1'b0);
    checkOutput("t4.home.done", 32'(flush_done_o), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t4.hold.done", 32'(flush_done_o), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t4.exit.ready", 32'(ready_o), 32'd1);
    checkOutput("t4.exit.done", 32'(flush_done_o), 32'd0);

    // Fire together with flush is still sent; dropping flush early does not exit DRAIN.
    applyStimulus(1'b1, 8'h21, 1'b0, 1'b1);
    checkLink("t4.fireflush", 1'b1, 8'h21, 3'd3, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkLink("t4.early", 1'b0, 8'h21, 3'd3, 1'b0);
    checkOutput("t4.early.done", 32'(flush_done_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t4.late.done", 32'(flush_done_o), 32'd1);
    checkOutput("t4.late.ready", 32'(ready_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t4.late.exit", 32'(ready_o), 32'd1);

    // Test 5: overflow at full credits is saturating and sticky.
    checkOutput("t5.pre.err", 32'(err_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t5.ovf.cnt", 32'(credit_cnt_o), 32'd4);
    checkOutput("t5.ovf.err", 32'(err_o), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
    checkLink("t5.send", 1'b1, 8'h30, 3'd3, 1'b1);
    checkOutput("t5.sticky", 32'(err_o), 32'd1);

    // Test 6: asynchronous reset mid-burst.
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
    checkLink("t6.pre", 1'b1, 8'h32, 3'd1, 1'b1);
    payload_i = 8'h33;
    #2;
    rst_n = 1'b0;
    #1;
    checkLink("t6.async", 1'b0, 8'h00, 3'd4, 1'b0);
    checkOutput("t6.async.err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    valid_i = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkLink("t6.release", 1'b0, 8'h00, 3'd4, 1'b0);
    checkOutput("t6.release.err", 32'(err_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule : tb_maze_credit_tx
